// File: rtl/wdg_supervisor.sv
// Window watchdog supervisor.
// Watches a toggling heartbeat level and requires every heartbeat edge to
// arrive within a [MIN_CYC, MAX_CYC] cycle window. On a violation it drives a
// timed active-low reset pulse and counts the fault. After MAX_FAULTS faults
// it locks out, holding the supervised logic in reset until clr_lock.
module wdg_supervisor #(
   parameter int CNT_W      = 16,
   parameter int MIN_CYC    = 4,
   parameter int MAX_CYC    = 100,
   parameter int PULSE_CYC  = 8,
   parameter int MAX_FAULTS = 3,
   parameter int FCNT_W     = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              hb,
   input  logic              clr_lock,
   output logic              armed,
   output logic              sys_rst_n,
   output logic              early_err,
   output logic              late_err,
   output logic              lockout,
   output logic [FCNT_W-1:0] fault_cnt,
   output logic [2:0]        state_o
);

   // Pulse counter only has to reach PULSE_CYC-1.
   localparam int PCNT_W = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;

   localparam logic [CNT_W-1:0]  L_MIN_GAP  = CNT_W'(MIN_CYC);
   localparam logic [CNT_W-1:0]  L_MAX_GAP  = CNT_W'(MAX_CYC);
   localparam logic [CNT_W-1:0]  L_GAP_ONE  = CNT_W'(1);
   localparam logic [PCNT_W-1:0] L_PLS_LAST = PCNT_W'(PULSE_CYC - 1);
   localparam logic [PCNT_W-1:0] L_PLS_ONE  = PCNT_W'(1);
   localparam logic [FCNT_W-1:0] L_FLT_MAX  = FCNT_W'(MAX_FAULTS);
   localparam logic [FCNT_W-1:0] L_FLT_ONE  = FCNT_W'(1);

   typedef enum logic [2:0] {
      S_DISARMED   = 3'd0,
      S_WAIT_FIRST = 3'd1,
      S_RUN        = 3'd2,
      S_FAULT      = 3'd3,
      S_LOCKED     = 3'd4
   } state_t;

   // heartbeat synchroniser and edge detector
   logic r_hb_m;
   logic r_hb_s;
   logic r_hb_d;
   logic w_edge;

   // FSM state, counters and registered outputs
   state_t              r_state;
   logic [CNT_W-1:0]    r_gap_cnt;
   logic [PCNT_W-1:0]   r_pulse_cnt;
   logic [FCNT_W-1:0]   r_fault_cnt;
   logic                r_armed;
   logic                r_sys_rst_n;
   logic                r_early;
   logic                r_late;
   logic                r_lockout;

   // next-state decision
   state_t              w_nxt;
   logic                w_early;
   logic                w_late;
   logic                w_clr_fcnt;
   logic                w_gap_at_max;
   logic                w_pulse_done;
   logic                w_entry;
   logic [FCNT_W-1:0]   w_fcnt_inc;

   // Two-flop synchroniser for the asynchronous heartbeat, plus one delay
   // flop so both heartbeat polarities show up as a one-cycle edge strobe.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_hb_m <= 1'b0;
         r_hb_s <= 1'b0;
         r_hb_d <= 1'b0;
      end else begin
         r_hb_m <= hb;
         r_hb_s <= r_hb_m;
         r_hb_d <= r_hb_s;
      end
   end

   assign w_edge       = r_hb_s ^ r_hb_d;
   assign w_gap_at_max = (r_gap_cnt == L_MAX_GAP);
   assign w_pulse_done = (r_pulse_cnt == L_PLS_LAST);
   assign w_fcnt_inc   = (r_fault_cnt == '1) ? r_fault_cnt : (r_fault_cnt + L_FLT_ONE);
   assign w_entry      = (w_nxt != r_state);

   // Next-state and fault classification. Dropping enable wins over any
   // fault seen in the same cycle; an edge at the timeout cycle is accepted.
   always_comb begin
      w_nxt      = r_state;
      w_early    = 1'b0;
      w_late     = 1'b0;
      w_clr_fcnt = 1'b0;
      unique case (r_state)
         S_DISARMED: begin
            if (enable) begin
               w_nxt = S_WAIT_FIRST;
            end
         end
         S_WAIT_FIRST: begin
            if (!enable) begin
               w_nxt = S_DISARMED;
            end else if (w_edge) begin
               w_nxt = S_RUN;
            end else if (w_gap_at_max) begin
               w_nxt  = S_FAULT;
               w_late = 1'b1;
            end
         end
         S_RUN: begin
            if (!enable) begin
               w_nxt = S_DISARMED;
            end else if (w_edge) begin
               if (r_gap_cnt < L_MIN_GAP) begin
                  w_nxt   = S_FAULT;
                  w_early = 1'b1;
               end
            end else if (w_gap_at_max) begin
               w_nxt  = S_FAULT;
               w_late = 1'b1;
            end
         end
         S_FAULT: begin
            // The pulse always runs to completion, whatever enable does.
            if (w_pulse_done) begin
               if (r_fault_cnt == L_FLT_MAX) begin
                  w_nxt = S_LOCKED;
               end else if (!enable) begin
                  w_nxt = S_DISARMED;
               end else begin
                  w_nxt = S_WAIT_FIRST;
               end
            end
         end
         S_LOCKED: begin
            if (clr_lock) begin
               w_nxt      = S_DISARMED;
               w_clr_fcnt = 1'b1;
            end
         end
         default: begin
            w_nxt = S_DISARMED;
         end
      endcase
   end

   // Supervisor FSM with its gap/pulse counters and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_DISARMED;
         r_gap_cnt   <= '0;
         r_pulse_cnt <= '0;
         r_fault_cnt <= '0;
         r_armed     <= 1'b0;
         r_sys_rst_n <= 1'b1;
         r_early     <= 1'b0;
         r_late      <= 1'b0;
         r_lockout   <= 1'b0;
      end else begin
         r_state     <= w_nxt;
         r_early     <= w_early;
         r_late      <= w_late;
         r_armed     <= (w_nxt == S_WAIT_FIRST) || (w_nxt == S_RUN);
         r_lockout   <= (w_nxt == S_LOCKED);
         r_sys_rst_n <= !((w_nxt == S_FAULT) || (w_nxt == S_LOCKED));

         if (w_clr_fcnt) begin
            r_fault_cnt <= '0;
         end else if (w_early || w_late) begin
            r_fault_cnt <= w_fcnt_inc;
         end

         // Gap restarts on every edge and on every state change.
         if (w_entry || w_edge) begin
            r_gap_cnt <= '0;
         end else if (r_gap_cnt != '1) begin
            r_gap_cnt <= r_gap_cnt + L_GAP_ONE;
         end

         // Pulse length counts cycles spent in FAULT since entry.
         if (w_entry) begin
            r_pulse_cnt <= '0;
         end else if (r_state == S_FAULT) begin
            r_pulse_cnt <= r_pulse_cnt + L_PLS_ONE;
         end
      end
   end

   assign armed     = r_armed;
   assign sys_rst_n = r_sys_rst_n;
   assign early_err = r_early;
   assign late_err  = r_late;
   assign lockout   = r_lockout;
   assign fault_cnt = r_fault_cnt;
   assign state_o   = r_state;

endmodule

// File: tb/tb_wdg_supervisor.sv
// Bench for wdg_supervisor: directed scenarios plus randomized heartbeat
// gaps, compared every cycle against a timestamp-based reference model.
module tb_wdg_supervisor;

   localparam int MIN_CYC    = 4;
   localparam int MAX_CYC    = 100;
   localparam int PULSE_CYC  = 8;
   localparam int MAX_FAULTS = 3;
   localparam int FCNT_W     = 4;

   localparam int ST_DIS  = 0;
   localparam int ST_WAIT = 1;
   localparam int ST_RUN  = 2;
   localparam int ST_FLT  = 3;
   localparam int ST_LCK  = 4;

   logic              clk      = 1'b0;
   logic              rst      = 1'b0;
   logic              enable   = 1'b0;
   logic              hb       = 1'b0;
   logic              clr_lock = 1'b0;
   logic              armed;
   logic              sys_rst_n;
   logic              early_err;
   logic              late_err;
   logic              lockout;
   logic [FCNT_W-1:0] fault_cnt;
   logic [2:0]        state_o;

   int n_checks = 0;
   int n_errors = 0;
   bit chk_on   = 1'b0;

   wdg_supervisor #(
      .CNT_W(16), .MIN_CYC(MIN_CYC), .MAX_CYC(MAX_CYC), .PULSE_CYC(PULSE_CYC),
      .MAX_FAULTS(MAX_FAULTS), .FCNT_W(FCNT_W)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable), .hb(hb), .clr_lock(clr_lock),
      .armed(armed), .sys_rst_n(sys_rst_n), .early_err(early_err),
      .late_err(late_err), .lockout(lockout), .fault_cnt(fault_cnt),
      .state_o(state_o)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: heartbeat seen through a 3-sample delay line; gap and
   // pulse length are derived from posedge timestamps, not counters.
   int     m_state;
   int     m_fcnt;
   bit     m_early;
   bit     m_late;
   bit     m_line [0:2];
   longint m_q;        // index of the current posedge
   longint m_clr_q;    // posedge at which the gap last restarted
   longint m_fault_q;  // posedge at which FAULT was entered

   task automatic model_reset();
      m_state   = ST_DIS;
      m_fcnt    = 0;
      m_early   = 0;
      m_late    = 0;
      m_line    = '{0, 0, 0};
      m_q       = 0;
      m_clr_q   = -1;
      m_fault_q = 0;
   endtask

   task automatic model_step();
      bit     seen;
      longint gap;
      int     nxt;
      seen    = m_line[1] ^ m_line[2];
      gap     = m_q - m_clr_q - 1;
      nxt     = m_state;
      m_early = 0;
      m_late  = 0;
      case (m_state)
         ST_DIS:  if (enable) nxt = ST_WAIT;
         ST_WAIT: begin
            if (!enable) nxt = ST_DIS;
            else if (seen) nxt = ST_RUN;
            else if (gap == MAX_CYC) begin nxt = ST_FLT; m_late = 1; end
         end
         ST_RUN: begin
            if (!enable) nxt = ST_DIS;
            else if (seen) begin
               if (gap < MIN_CYC) begin nxt = ST_FLT; m_early = 1; end
            end else if (gap == MAX_CYC) begin nxt = ST_FLT; m_late = 1; end
         end
         ST_FLT: begin
            if (m_q - m_fault_q == PULSE_CYC) begin
               if (m_fcnt == MAX_FAULTS) nxt = ST_LCK;
               else if (!enable) nxt = ST_DIS;
               else nxt = ST_WAIT;
            end
         end
         default: if (clr_lock) begin nxt = ST_DIS; m_fcnt = 0; end
      endcase
      if (nxt == ST_FLT && m_state != ST_FLT) begin
         if (m_fcnt < (1 << FCNT_W) - 1) m_fcnt++;
         m_fault_q = m_q;
      end
      if (nxt != m_state || seen) m_clr_q = m_q;
      m_state   = nxt;
      m_line[2] = m_line[1];
      m_line[1] = m_line[0];
      m_line[0] = hb;
      m_q++;
   endtask

   // advance the model on the same edges as the DUT
   always @(posedge clk or negedge rst) begin
      if (!rst) model_reset();
      else model_step();
   end

   // compare every output once per cycle, away from the active edge
   always @(negedge clk) begin
      if (chk_on) begin
         check_val("state",     int'(state_o),   m_state);
         check_val("armed",     int'(armed),     int'(m_state == ST_WAIT || m_state == ST_RUN));
         check_val("sys_rst_n", int'(sys_rst_n), int'(!(m_state == ST_FLT || m_state == ST_LCK)));
         check_val("lockout",   int'(lockout),   int'(m_state == ST_LCK));
         check_val("early_err", int'(early_err), int'(m_early));
         check_val("late_err",  int'(late_err),  int'(m_late));
         check_val("fault_cnt", int'(fault_cnt), m_fcnt);
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic gap_then_toggle(input int n);
      step(n);
      hb = ~hb;
   endtask

   task automatic pulse_clr();
      clr_lock = 1'b1;
      step(1);
      clr_lock = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout t=%0t", $time);
      $fatal(1, "timeout");
   end

   initial begin
      int gaps [10] = '{10, 3, 20, 10, 5, 101, 10, 4, 15, 102};
      model_reset();
      chk_on = 1'b1;
      #30 rst = 1'b1;
      step(2);
      check_val("reset_state", int'(state_o), 0);

      // steady heartbeat every 10 cycles
      enable = 1'b1;
      for (int i = 0; i < 20; i++) gap_then_toggle(10);
      step(5);
      check_val("run_state", int'(state_o), 2);
      check_val("run_fcnt", int'(fault_cnt), 0);
      $display("txn startup: 20 toggles, state=%0d", state_o);

      // heartbeat stalls -> late fault, pulse, back to WAIT_FIRST
      step(130);
      check_val("after_late_fcnt", int'(fault_cnt), 1);
      check_val("after_late_state", int'(state_o), 1);
      $display("txn stall: fault_cnt=%0d", fault_cnt);

      // window boundaries
      pulse_clr();
      for (int i = 0; i < 10; i++) begin
         gap_then_toggle(gaps[i]);
         $display("txn gap=%0d state=%0d fcnt=%0d", gaps[i], state_o, fault_cnt);
      end
      step(30);

      // force lockout with stalled heartbeat, then wiggle enable
      step(420);
      check_val("lock_state", int'(state_o), 4);
      for (int i = 0; i < 22; i++) begin
         enable = ~enable;
         step(10);
      end
      check_val("lock_held", int'(sys_rst_n), 0);
      enable = 1'b1;
      pulse_clr();
      check_val("clr_state", int'(state_o), 0);
      check_val("clr_fcnt", int'(fault_cnt), 0);
      $display("txn lockout cleared");

      // disable in RUN, then disable during FAULT
      step(2);
      for (int i = 0; i < 4; i++) gap_then_toggle(10);
      step(4);
      enable = 1'b0;
      step(1);
      check_val("dis_state", int'(state_o), 0);
      enable = 1'b1;
      step(3);
      gap_then_toggle(2);
      step(110);
      enable = 1'b0;
      step(20);
      check_val("dis_fault_state", int'(state_o), 0);
      enable = 1'b1;
      $display("txn enable drop checks done");

      // asynchronous reset in the middle of a FAULT pulse
      for (int guard = 0; guard < 300 && m_state != ST_FLT; guard++) step(1);
      check_val("reach_fault", int'(state_o), 3);
      step(2);
      #2 rst = 1'b0;
      #1;
      check_val("areset_state", int'(state_o), 0);
      check_val("areset_sysrst", int'(sys_rst_n), 1);
      check_val("areset_fcnt", int'(fault_cnt), 0);
      check_val("areset_armed", int'(armed), 0);
      @(negedge clk);
      rst = 1'b1;
      step(2);
      check_val("rearm_state", int'(state_o), 1);
      $display("txn async reset mid-fault");

      // randomized heartbeat gaps with occasional enable drops and clears
      for (int i = 0; i < 300; i++) begin
         int r;
         int g;
         r = int'($urandom_range(0, 99));
         if (r < 5) begin
            enable = 1'b0;
            step(int'($urandom_range(1, 6)));
            enable = 1'b1;
         end else if (r < 9) begin
            pulse_clr();
         end
         r = int'($urandom_range(0, 2));
         if (r == 0)      g = int'($urandom_range(1, 8));
         else if (r == 1) g = int'($urandom_range(97, 104));
         else             g = int'($urandom_range(1, 115));
         gap_then_toggle(g);
         $display("txn rnd %0d gap=%0d state=%0d fcnt=%0d", i, g, state_o, fault_cnt);
      end
      step(10);

      chk_on = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
